tia_lfsr_counter: RTL and testbench

Parametrised polynomial (LFSR) counter that generalises the TIA horizontal counter. It has configurable width, feedback taps and period, plus a programmable bank of state decoders. It runs on the single master clock, with a clock-enable strobe in place of the two-phase clock. The horizontal and audio/object counters that need a short-period, cheap counter with decoded event pulses instantiate it.

---
 rtl/tia_lfsr_counter_if.sv | 35 +++
 rtl/tia_lfsr_counter.sv | 137 +++++++++++++
 tb/tb_tia_lfsr_counter.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/tia_lfsr_counter_if.sv
// tia_lfsr_counter_if
//   Signal bundle for one tia_lfsr_counter instance.
//   Parameters: WIDTH (LFSR width), IDXW (index width), NDEC (decode channels).
//   master: drives en/rsyn and observes the counter outputs.
//   slave : the counter itself.
//     en    - advance strobe
//     rsyn  - synchronous restart request
//     out   - current LFSR state
//     idx   - binary index of the current state
//     wrap  - high while idx == PERIOD-1
//     dec   - per-channel decode of idx
//     rsynd - registered acknowledge of rsyn
interface tia_lfsr_counter_if #(
    parameter int unsigned WIDTH = 6,
    parameter int unsigned IDXW  = 6,
    parameter int unsigned NDEC  = 2
);
    logic             en;
    logic             rsyn;
    logic [WIDTH-1:0] out;
    logic [IDXW-1:0]  idx;
    logic             wrap;
    logic [NDEC-1:0]  dec;
    logic             rsynd;

    modport master (
        output en, rsyn,
        input  out, idx, wrap, dec, rsynd
    );

    modport slave (
        input  en, rsyn,
        output out, idx, wrap, dec, rsynd
    );
endinterface

// File: rtl/tia_lfsr_counter.sv
// tia_lfsr_counter
//   Parametrised XNOR-feedback LFSR counter with a programmable period and a
//   bank of registered state decoders (generalised TIA horizontal counter).
//   Ports:
//     clk - master clock, rising edge
//     rl  - asynchronous active-low reset
//     bus - tia_lfsr_counter_if.slave (en, rsyn in; out, idx, wrap, dec, rsynd out)
//   The interface must be instantiated with IDXW = $clog2(PERIOD) (1 for PERIOD=2).
module tia_lfsr_counter #(
    parameter int unsigned         WIDTH   = 6,
    parameter logic [WIDTH-1:0]    TAPS    = 6'b000011,
    parameter int unsigned         PERIOD  = 57,
    parameter int unsigned         NDEC    = 2,
    parameter logic [NDEC*8-1:0]   DEC_IDX = {8'd0, 8'd56}
) (
    input  logic              clk,
    input  logic              rl,
    tia_lfsr_counter_if.slave bus
);

    localparam int unsigned IDXW = (PERIOD > 2) ? $clog2(PERIOD) : 1;

    function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
        return {~^(s & TAPS), s[WIDTH-1:1]};
    endfunction

    // State reached from zero after PERIOD-1 steps: the last state of the cycle.
    function automatic logic [WIDTH-1:0] calc_end_state();
        logic [WIDTH-1:0] s;
        s = '0;
        for (int unsigned i = 1; i < PERIOD; i++) begin
            s = lfsr_step(s);
        end
        return s;
    endfunction

    // The sequence must not revisit zero before the end of the requested period.
    function automatic bit calc_period_ok();
        logic [WIDTH-1:0] s;
        s = '0;
        for (int unsigned i = 1; i < PERIOD; i++) begin
            s = lfsr_step(s);
            if (s == '0) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic bit calc_dec_ok();
        for (int unsigned k = 0; k < NDEC; k++) begin
            if (32'(DEC_IDX[8*k +: 8]) >= PERIOD) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Channels decoding index 0 are active straight out of reset.
    function automatic logic [NDEC-1:0] calc_dec_rst();
        logic [NDEC-1:0] r;
        r = '0;
        for (int unsigned k = 0; k < NDEC; k++) begin
            r[k] = (DEC_IDX[8*k +: 8] == 8'd0);
        end
        return r;
    endfunction

    localparam logic [WIDTH-1:0] END_STATE = calc_end_state();
    localparam bit               PERIOD_OK = calc_period_ok();
    localparam bit               DEC_OK    = calc_dec_ok();
    localparam logic [NDEC-1:0]  DEC_RST   = calc_dec_rst();
    localparam logic [IDXW-1:0]  LAST_IDX  = IDXW'(PERIOD - 1);

    if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
        $error("tia_lfsr_counter: WIDTH must be 2..16");
    end
    if (NDEC < 1 || NDEC > 8) begin : g_bad_ndec
        $error("tia_lfsr_counter: NDEC must be 1..8");
    end
    if (PERIOD < 2 || !PERIOD_OK) begin : g_bad_period
        $error("tia_lfsr_counter: PERIOD exceeds the natural period of TAPS or is below 2");
    end
    if (!DEC_OK) begin : g_bad_dec
        $error("tia_lfsr_counter: every DEC_IDX entry must be below PERIOD");
    end

    logic [WIDTH-1:0] out_q,  out_d;
    logic [IDXW-1:0]  idx_q,  idx_d;
    logic             wrap_q, wrap_d;
    logic [NDEC-1:0]  dec_q,  dec_d;
    logic             rsynd_q;

    // wrap/dec are decoded from the next index so the registered flags line
    // up with out/idx in the same cycle.
    always_comb begin
        out_d = out_q;
        idx_d = idx_q;
        if (bus.rsyn) begin
            out_d = '0;
            idx_d = '0;
        end else if (bus.en) begin
            if (out_q == END_STATE) begin
                out_d = '0;
                idx_d = '0;
            end else begin
                out_d = lfsr_step(out_q);
                idx_d = idx_q + IDXW'(1);
            end
        end

        wrap_d = (idx_d == LAST_IDX);
        dec_d  = '0;
        for (int unsigned k = 0; k < NDEC; k++) begin
            dec_d[k] = (32'(idx_d) == 32'(DEC_IDX[8*k +: 8]));
        end
    end

    always_ff @(posedge clk or negedge rl) begin
        if (!rl) begin
            out_q   <= '0;
            idx_q   <= '0;
            wrap_q  <= 1'b0;
            dec_q   <= DEC_RST;
            rsynd_q <= 1'b0;
        end else begin
            out_q   <= out_d;
            idx_q   <= idx_d;
            wrap_q  <= wrap_d;
            dec_q   <= dec_d;
            rsynd_q <= bus.rsyn;
        end
    end

    assign bus.out   = out_q;
    assign bus.idx   = idx_q;
    assign bus.wrap  = wrap_q;
    assign bus.dec   = dec_q;
    assign bus.rsynd = rsynd_q;

endmodule

// File: tb/tb_tia_lfsr_counter.sv
// tb_tia_lfsr_counter
//   Drives a default-parameter counter and a WIDTH=4/PERIOD=10 counter from the
//   same en/rsyn/rl stimulus and compares both against an index-based model.
module tb_tia_lfsr_counter;

    localparam int PA = 57;
    localparam int PB = 10;

    logic clk;
    logic rl;

    tia_lfsr_counter_if #(.WIDTH(6), .IDXW(6), .NDEC(2)) bus_a ();
    tia_lfsr_counter_if #(.WIDTH(4), .IDXW(4), .NDEC(1)) bus_b ();

    assign bus_b.en   = bus_a.en;
    assign bus_b.rsyn = bus_a.rsyn;

    tia_lfsr_counter #(
        .WIDTH(6), .TAPS(6'b000011), .PERIOD(57), .NDEC(2), .DEC_IDX({8'd0, 8'd56})
    ) u_dut_a (
        .clk(clk), .rl(rl), .bus(bus_a)
    );

    tia_lfsr_counter #(
        .WIDTH(4), .TAPS(4'b0011), .PERIOD(10), .NDEC(1), .DEC_IDX(8'd3)
    ) u_dut_b (
        .clk(clk), .rl(rl), .bus(bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    int seq_a [PA];
    int seq_b [PB];
    int ma = 0;
    int mb = 0;
    int m_rsynd = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // XNOR of the tapped bits shifted in at the top.
    function automatic int lfsr_next(input int s, input int width, input int taps);
        int fb;
        fb = ($countones(s & taps) % 2 == 0) ? 1 : 0;
        return (fb << (width - 1)) | (s >> 1);
    endfunction

    task automatic check_all();
        check_eq("a_out",   32'(bus_a.out),   32'(seq_a[ma]));
        check_eq("a_idx",   32'(bus_a.idx),   32'(ma));
        check_eq("a_wrap",  32'(bus_a.wrap),  32'(ma == PA - 1));
        check_eq("a_dec",   32'(bus_a.dec),   32'({(ma == 0), (ma == 56)}));
        check_eq("a_rsynd", 32'(bus_a.rsynd), 32'(m_rsynd));
        check_eq("b_out",   32'(bus_b.out),   32'(seq_b[mb]));
        check_eq("b_idx",   32'(bus_b.idx),   32'(mb));
        check_eq("b_wrap",  32'(bus_b.wrap),  32'(mb == PB - 1));
        check_eq("b_dec",   32'(bus_b.dec),   32'(mb == 3));
        check_eq("b_rsynd", 32'(bus_b.rsynd), 32'(m_rsynd));
    endtask

    task automatic tick(input logic e, input logic r);
        bus_a.en   = e;
        bus_a.rsyn = r;
        @(posedge clk);
        if (r) begin
            ma = 0;
            mb = 0;
        end else if (e) begin
            ma = (ma + 1) % PA;
            mb = (mb + 1) % PB;
        end
        m_rsynd = int'(r);
        #1;
        check_all();
    endtask

    // Reset pulse placed between clock edges; outputs must clear with no edge.
    task automatic async_reset();
        #1;
        rl = 1'b0;
        ma = 0;
        mb = 0;
        m_rsynd = 0;
        #1;
        check_all();
        check_eq("rst_dec_a", 32'(bus_a.dec), 32'(2'b10));
        @(negedge clk);
        rl = 1'b1;
    endtask

    initial begin
        seq_a[0] = 0;
        for (int i = 1; i < PA; i++) seq_a[i] = lfsr_next(seq_a[i-1], 6, 6'b000011);
        seq_b[0] = 0;
        for (int i = 1; i < PB; i++) seq_b[i] = lfsr_next(seq_b[i-1], 4, 4'b0011);

        rl = 1'b1;
        bus_a.en   = 1'b0;
        bus_a.rsyn = 1'b0;
        #1 rl = 1'b0;
        #1;
        check_all();
        check_eq("rst_out", 32'(bus_a.out), 32'(0));
        check_eq("rst_dec", 32'(bus_a.dec), 32'(2'b10));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rl = 1'b1;

        // Free run: literal anchors from the documented sequence.
        for (int i = 1; i <= 114; i++) begin
            tick(1'b1, 1'b0);
            if (i == 1)   check_eq("seq1",   32'(bus_a.out), 32'(6'b100000));
            if (i == 2)   check_eq("seq2",   32'(bus_a.out), 32'(6'b110000));
            if (i == 6)   check_eq("seq6",   32'(bus_a.out), 32'(6'b011111));
            if (i == 57)  check_eq("wrap57", 32'(bus_a.out), 32'(0));
            if (i == 114) check_eq("wrap114", 32'(bus_a.out), 32'(0));
        end

        // 1-of-4 enable: one full cycle takes 228 clocks.
        for (int c = 0; c < 228; c++) tick(logic'(c % 4 == 0), 1'b0);
        check_eq("gate228", 32'(bus_a.out), 32'(0));

        // Restart at idx 30 with en low.
        repeat (30) tick(1'b1, 1'b0);
        tick(1'b0, 1'b1);
        check_eq("rsyn_out", 32'(bus_a.out), 32'(0));
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        check_eq("rsyn_resume", 32'(bus_a.idx), 32'(1));

        // Asynchronous reset at idx 40.
        repeat (39) tick(1'b1, 1'b0);
        check_eq("pre_rst_idx", 32'(bus_a.idx), 32'(40));
        async_reset();
        tick(1'b1, 1'b0);
        check_eq("post_rst", 32'(bus_a.out), 32'(6'b100000));

        // rsyn coinciding with wrap, then a held rsyn.
        repeat (55) tick(1'b1, 1'b0);
        tick(1'b1, 1'b1);
        repeat (3) tick(1'b1, 1'b1);
        tick(1'b1, 1'b0);

        // Random stimulus.
        repeat (3000) begin
            tick(logic'($urandom % 4 != 0), logic'($urandom % 40 == 0));
            if ($urandom % 600 == 0) async_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
